// File: rtl/pc_stack_unit.sv
// pc_stack_unit: program counter with jump, relative branch, and a return-address stack
// for call/ret. Sticky flags record a call on a full stack and a ret on an empty stack.
// Ports:
//   clk, rst (async, active-low)
//   Command strobes: load_pc, call, ret, rel_pc, inc_pc, clr_err
//   Operands: data_in (jump/call target), offset (signed branch offset)
//   Outputs: count, stack_top, depth, stack_full, stack_empty, ovf_err, unf_err
module pc_stack_unit #(
   parameter int          AW        = 8,
   parameter int          DEPTH     = 4,
   parameter logic [AW-1:0] RESET_VEC = '0
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         load_pc,
   input  logic                         call,
   input  logic                         ret,
   input  logic                         rel_pc,
   input  logic                         inc_pc,
   input  logic                         clr_err,
   input  logic [AW-1:0]                data_in,
   input  logic [AW-1:0]                offset,
   output logic [AW-1:0]                count,
   output logic [AW-1:0]                stack_top,
   output logic [$clog2(DEPTH+1)-1:0]   depth,
   output logic                         stack_full,
   output logic                         stack_empty,
   output logic                         ovf_err,
   output logic                         unf_err
);

   localparam int DW = $clog2(DEPTH+1);
   localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [AW-1:0] stack [DEPTH];
   logic [AW-1:0] count_nxt;
   logic [DW-1:0] depth_nxt;
   logic          ovf_nxt;
   logic          unf_nxt;
   logic          push;
   logic [IW-1:0] push_idx;
   logic [IW-1:0] top_idx;

   assign stack_full  = (depth == DW'(DEPTH));
   assign stack_empty = (depth == '0);
   assign push_idx    = IW'(depth);
   assign top_idx     = IW'(depth - 1'b1);
   assign stack_top   = stack_empty ? '0 : stack[top_idx];

   always_comb begin
      count_nxt = count;
      depth_nxt = depth;
      push      = 1'b0;
      ovf_nxt   = clr_err ? 1'b0 : ovf_err;
      unf_nxt   = clr_err ? 1'b0 : unf_err;
      priority case (1'b1)
         load_pc: count_nxt = data_in;
         call: begin
            if (stack_full) begin
               ovf_nxt = 1'b1;
            end else begin
               push      = 1'b1;
               depth_nxt = depth + 1'b1;
               count_nxt = data_in;
            end
         end
         ret: begin
            if (stack_empty) begin
               unf_nxt = 1'b1;
            end else begin
               depth_nxt = depth - 1'b1;
               count_nxt = stack[top_idx];
            end
         end
         rel_pc:  count_nxt = count + offset;
         inc_pc:  count_nxt = count + 1'b1;
         default: count_nxt = count;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         count   <= RESET_VEC;
         depth   <= '0;
         ovf_err <= 1'b0;
         unf_err <= 1'b0;
      end else begin
         count   <= count_nxt;
         depth   <= depth_nxt;
         ovf_err <= ovf_nxt;
         unf_err <= unf_nxt;
      end
   end

   // Storage needs no reset: only entries below depth are ever read.
   always_ff @(posedge clk) begin
      if (push) begin
         stack[push_idx] <= count + 1'b1;
      end
   end

endmodule

// File: tb/tb_pc_stack_unit.sv
// tb_pc_stack_unit: directed test of pc_stack_unit (AW=8, DEPTH=4).
// Each step drives commands for one clock and checks the outputs on the falling edge.
module tb_pc_stack_unit;

   logic       clk = 1'b0;
   logic       rst;
   logic       load_pc, call, ret, rel_pc, inc_pc, clr_err;
   logic [7:0] data_in, offset;
   logic [7:0] count, stack_top;
   logic [2:0] depth;
   logic       stack_full, stack_empty, ovf_err, unf_err;

   int n_assert = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   pc_stack_unit #(.AW(8), .DEPTH(4), .RESET_VEC(8'h00)) dut (
      .clk(clk), .rst(rst),
      .load_pc(load_pc), .call(call), .ret(ret),
      .rel_pc(rel_pc), .inc_pc(inc_pc), .clr_err(clr_err),
      .data_in(data_in), .offset(offset),
      .count(count), .stack_top(stack_top), .depth(depth),
      .stack_full(stack_full), .stack_empty(stack_empty),
      .ovf_err(ovf_err), .unf_err(unf_err)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Drive one command for one cycle; returns on the next falling edge.
   task automatic cmd(input logic lp, input logic c, input logic r,
                      input logic rp, input logic ip, input logic ce,
                      input logic [7:0] d, input logic [7:0] o);
      load_pc = lp; call = c; ret = r;
      rel_pc = rp; inc_pc = ip; clr_err = ce;
      data_in = d; offset = o;
      @(negedge clk);
      load_pc = 0; call = 0; ret = 0;
      rel_pc = 0; inc_pc = 0; clr_err = 0;
   endtask

   task automatic idle();
      cmd(0, 0, 0, 0, 0, 0, 8'h00, 8'h00);
   endtask
   task automatic do_load(input logic [7:0] d);
      cmd(1, 0, 0, 0, 0, 0, d, 8'h00);
   endtask
   task automatic do_call(input logic [7:0] d);
      cmd(0, 1, 0, 0, 0, 0, d, 8'h00);
   endtask
   task automatic do_ret();
      cmd(0, 0, 1, 0, 0, 0, 8'h00, 8'h00);
   endtask
   task automatic do_inc();
      cmd(0, 0, 0, 0, 1, 0, 8'h00, 8'h00);
   endtask
   task automatic do_rel(input logic [7:0] o);
      cmd(0, 0, 0, 1, 0, 0, 8'h00, o);
   endtask

   task automatic chk_reset(input string p);
      chk({p, "_count"}, 32'(count), 32'h00);
      chk({p, "_depth"}, 32'(depth), 32'd0);
      chk({p, "_empty"}, 32'(stack_empty), 32'd1);
      chk({p, "_full"}, 32'(stack_full), 32'd0);
      chk({p, "_top"}, 32'(stack_top), 32'h00);
      chk({p, "_ovf"}, 32'(ovf_err), 32'd0);
      chk({p, "_unf"}, 32'(unf_err), 32'd0);
   endtask

   initial begin
      rst = 1'b0;
      load_pc = 0; call = 0; ret = 0;
      rel_pc = 0; inc_pc = 0; clr_err = 0;
      data_in = 8'h00; offset = 8'h00;
      #3;
      chk_reset("por");
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;

      // Reset and increment
      do_inc(); chk("inc1", 32'(count), 32'h01);
      do_inc(); chk("inc2", 32'(count), 32'h02);
      do_inc(); chk("inc3", 32'(count), 32'h03);
      chk("inc_empty", 32'(stack_empty), 32'd1);
      do_load(8'hFF); chk("load_ff", 32'(count), 32'hFF);
      do_inc(); chk("inc_wrap", 32'(count), 32'h00);

      // Call/return nesting
      do_load(8'h10);
      do_call(8'h40);
      chk("call1_count", 32'(count), 32'h40);
      chk("call1_depth", 32'(depth), 32'd1);
      chk("call1_top", 32'(stack_top), 32'h11);
      do_call(8'h80);
      chk("call2_count", 32'(count), 32'h80);
      chk("call2_depth", 32'(depth), 32'd2);
      chk("call2_top", 32'(stack_top), 32'h41);
      do_ret();
      chk("ret1_count", 32'(count), 32'h41);
      chk("ret1_depth", 32'(depth), 32'd1);
      chk("ret1_top", 32'(stack_top), 32'h11);
      do_ret();
      chk("ret2_count", 32'(count), 32'h11);
      chk("ret2_depth", 32'(depth), 32'd0);
      chk("ret2_top", 32'(stack_top), 32'h00);
      chk("ret2_empty", 32'(stack_empty), 32'd1);

      // Overflow
      do_call(8'h01);
      do_call(8'h02);
      do_call(8'h03);
      chk("fill3_full", 32'(stack_full), 32'd0);
      do_call(8'h04);
      chk("fill_depth", 32'(depth), 32'd4);
      chk("fill_full", 32'(stack_full), 32'd1);
      chk("fill_top", 32'(stack_top), 32'h04);
      chk("fill_count", 32'(count), 32'h04);
      do_call(8'hAA);
      chk("ovf_count", 32'(count), 32'h04);
      chk("ovf_depth", 32'(depth), 32'd4);
      chk("ovf_top", 32'(stack_top), 32'h04);
      chk("ovf_set", 32'(ovf_err), 32'd1);
      idle(); idle();
      chk("ovf_sticky", 32'(ovf_err), 32'd1);
      do_inc();
      chk("ovf_inc_count", 32'(count), 32'h05);
      chk("ovf_sticky2", 32'(ovf_err), 32'd1);
      cmd(0, 0, 0, 0, 0, 1, 8'h00, 8'h00);
      chk("ovf_clr", 32'(ovf_err), 32'd0);
      do_ret(); chk("pop4", 32'(count), 32'h04);
      do_ret(); chk("pop3", 32'(count), 32'h03);
      do_ret(); chk("pop2", 32'(count), 32'h02);
      do_ret(); chk("pop1", 32'(count), 32'h12);
      chk("pop_depth", 32'(depth), 32'd0);

      // Back-to-back call then ret
      do_call(8'h50);
      chk("b2b_call", 32'(count), 32'h50);
      do_ret();
      chk("b2b_ret", 32'(count), 32'h13);
      chk("b2b_depth", 32'(depth), 32'd0);

      // Underflow
      do_load(8'h20);
      do_ret();
      chk("unf_count", 32'(count), 32'h20);
      chk("unf_depth", 32'(depth), 32'd0);
      chk("unf_set", 32'(unf_err), 32'd1);
      chk("unf_no_ovf", 32'(ovf_err), 32'd0);
      cmd(0, 0, 1, 0, 0, 1, 8'h00, 8'h00);
      chk("unf_set_wins", 32'(unf_err), 32'd1);
      cmd(0, 0, 0, 0, 0, 1, 8'h00, 8'h00);
      chk("unf_clr", 32'(unf_err), 32'd0);

      // Relative branch and priority
      do_load(8'h05);
      do_rel(8'hFE);
      chk("rel_neg", 32'(count), 32'h03);
      do_load(8'hF0);
      do_rel(8'h7F);
      chk("rel_wrap", 32'(count), 32'h6F);
      cmd(1, 1, 0, 0, 0, 0, 8'h33, 8'h00);
      chk("pri_load_count", 32'(count), 32'h33);
      chk("pri_load_depth", 32'(depth), 32'd0);
      cmd(0, 0, 0, 1, 1, 0, 8'h00, 8'h02);
      chk("pri_rel_inc", 32'(count), 32'h35);
      cmd(0, 1, 1, 0, 1, 0, 8'h60, 8'h00);
      chk("pri_call_count", 32'(count), 32'h60);
      chk("pri_call_depth", 32'(depth), 32'd1);
      chk("pri_call_top", 32'(stack_top), 32'h36);
      cmd(0, 0, 1, 1, 1, 0, 8'h00, 8'h10);
      chk("pri_ret_count", 32'(count), 32'h36);
      chk("pri_ret_depth", 32'(depth), 32'd0);

      // Async reset mid-stack
      do_ret();
      chk("pre_rst_unf", 32'(unf_err), 32'd1);
      do_call(8'h01);
      do_call(8'h02);
      do_call(8'h03);
      chk("pre_rst_depth", 32'(depth), 32'd3);
      chk("pre_rst_count", 32'(count), 32'h03);
      #2 rst = 1'b0;
      #1;
      chk_reset("arst");
      @(negedge clk);
      chk("arst_hold", 32'(count), 32'h00);
      rst = 1'b1;
      do_inc();
      chk("post_rst_inc", 32'(count), 32'h01);
      chk("post_rst_depth", 32'(depth), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
